// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Stall vector layout, bus widths, hold-FSM states and small helpers.
package if_fetch_pkg;

  localparam int STALL_WD    = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] PC_INC_DEF   = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } hold_state_e;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's SRAM port, branch bus, stall vector and IF->ID bus.
// master = fetch stage, slave = surrounding pipeline / memory.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic [STALL_WD-1:0]    stall;
  logic [BR_WD-1:0]       br_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic [31:0]            inst_sram_rdata;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic [31:0]            if_inst;
  logic                   if_adel;

  modport master (
    input  stall, br_bus, inst_sram_rdata,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output if_to_id_bus, if_inst, if_adel
  );

  modport slave (
    output stall, br_bus, inst_sram_rdata,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  if_to_id_bus, if_inst, if_adel
  );

endinterface

// File: rtl/if_fetch_inst_hold.sv
// Keeps the instruction shown to ID steady while IF/ID is stalled; the SRAM is
// disabled during the stall, so its output is captured on the stall's first cycle.
module if_fetch_inst_hold
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        id_stop,
  input  logic        id_ce,
  input  logic [31:0] rdata,
  output logic [31:0] if_inst
);

  hold_state_e state_q, state_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    case (state_q)
      IDLE: if (fetch_go) state_d = RUN;
      RUN: begin
        if (id_stop) begin
          state_d     = HOLD;
          hold_inst_d = rdata;
        end
      end
      HOLD: if (!id_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d     = IDLE;
      hold_inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    hold_inst_q <= hold_inst_d;
  end

  // Anything not backed by a valid fetch is presented to ID as a nop.
  always_comb begin
    if_inst = '0;
    if (!rst && id_ce) begin
      case (state_q)
        RUN:     if_inst = rdata;
        HOLD:    if_inst = hold_inst_q;
        default: if_inst = '0;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and the
// IF->ID bus, and remembers a branch redirect that arrives while the PC is stalled.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master io
);

  br_bus_t     br;
  if_to_id_t   id_bus;
  logic        pc_stop;
  logic        id_stop;
  logic        adel;
  logic        id_ce;
  logic [31:0] next_pc;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_pend_addr_q, br_pend_addr_d;
  logic        unused_stall;

  assign br           = io.br_bus;
  assign pc_stop      = io.stall[0] == STOP;
  assign id_stop      = io.stall[1] == STOP;
  assign unused_stall = ^io.stall[STALL_WD-1:2];

  // A live branch beats a remembered one, which beats sequential fetch.
  always_comb begin
    if (br.br_e)        next_pc = br.br_addr;
    else if (br_pend_q) next_pc = br_pend_addr_q;
    else                next_pc = pc_q + PC_INC;
  end

  always_comb begin
    pc_d           = pc_q;
    ce_d           = ce_q;
    br_pend_d      = br_pend_q;
    br_pend_addr_d = br_pend_addr_q;
    if (rst) begin
      pc_d           = RESET_PC - PC_INC;
      ce_d           = 1'b0;
      br_pend_d      = 1'b0;
      br_pend_addr_d = '0;
    end else if (!pc_stop) begin
      pc_d      = next_pc;
      ce_d      = 1'b1;
      br_pend_d = 1'b0;
    end else if (br.br_e) begin
      br_pend_d      = 1'b1;
      br_pend_addr_d = br.br_addr;
    end
  end

  always_ff @(posedge clk) begin
    pc_q           <= pc_d;
    ce_q           <= ce_d;
    br_pend_q      <= br_pend_d;
    br_pend_addr_q <= br_pend_addr_d;
  end

  assign adel  = !rst && ce_q && is_misaligned(pc_q);
  assign id_ce = !rst && ce_q && !adel;

  assign id_bus.ce = id_ce;
  assign id_bus.pc = rst ? 32'h0 : pc_q;

  assign io.if_adel         = adel;
  assign io.if_to_id_bus    = id_bus;
  assign io.inst_sram_en    = !rst && !pc_stop && !is_misaligned(next_pc);
  assign io.inst_sram_addr  = pc_stop ? pc_q : next_pc;
  assign io.inst_sram_wen   = 4'h0;
  assign io.inst_sram_wdata = 32'h0;

  if_fetch_inst_hold u_inst_hold (
    .clk      (clk),
    .rst      (rst),
    .fetch_go (!pc_stop),
    .id_stop  (id_stop),
    .id_ce    (id_ce),
    .rdata    (io.inst_sram_rdata),
    .if_inst  (io.if_inst)
  );

endmodule
